data_mem_responder: RTL and testbench

Memory-side responder for the five-stage pipeline's MEM-stage load/store port. It accepts one word or byte-masked access per request from the pipeline and services it after a configurable number of wait states from an internal word-addressed RAM. It drives a stall signal toward the hazard unit while an access is outstanding, which lets the pipeline run against slow memory.

---
 rtl/data_mem_responder_pkg.sv | 12 +
 rtl/data_mem_responder_dmem_ram.sv | 30 +++
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the MEM-stage data memory responder: FSM encoding and byte-lane count.
package data_mem_responder_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_e;

endpackage

// File: rtl/data_mem_responder_dmem_ram.sv
// Word-addressed data RAM with per-byte write enables and asynchronous read.
module dmem_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: accepts one access, inserts WAIT_CYCLES wait states,
// then completes it against dmem_ram while stalling the pipeline through mem_busy.
//   state | meaning
//   IDLE  | no access outstanding; a valid request is captured at the next edge
//   WAIT  | wait-state down-counter running; pipeline stalled
//   RESP  | access performed, resp_ready high for this single cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic        mem_busy
);

    memState_e         state;
    logic [3:0]        waitCnt;
    logic              respReadyQ;
    logic              reqWe;
    logic              reqErr;
    logic [BE_W-1:0]   reqBe;
    logic [ADDR_W-1:0] reqIdx;
    logic [31:0]       reqWdata;
    logic              newReqErr;
    logic              ramWe;
    logic [31:0]       ramRdata;

    assign newReqErr = (|req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            respReadyQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        reqWe    <= req_we;
                        reqBe    <= req_be;
                        reqIdx   <= req_addr[ADDR_W+1:2];
                        reqWdata <= req_wdata;
                        reqErr   <= newReqErr;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            respReadyQ <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state      <= RESP;
                        respReadyQ <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    respReadyQ <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    respReadyQ <= 1'b0;
                end
            endcase
        end
    end

    // A reset landing on the RESP cycle must abort the store, so it gates the write too.
    assign ramWe = (state == RESP) && reqWe && !reqErr && !reset;

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uRam (
        .clk   (clk),
        .we    (ramWe),
        .be    (reqBe),
        .addr  (reqIdx),
        .wdata (reqWdata),
        .rdata (ramRdata)
    );

    assign resp_ready = respReadyQ;
    assign addr_err   = (state == RESP) && reqErr;
    assign resp_rdata = ((state == RESP) && !reqWe && !reqErr) ? ramRdata : 32'd0;
    assign mem_busy   = ((state == IDLE) && req_valid) || (state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=2 and 0) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqWe;
    logic [3:0]  reqBe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    logic        respReady [2];
    logic [31:0] respRdata [2];
    logic        addrErr   [2];
    logic        memBusy   [2];

    int passCnt  = 0;
    int checkCnt = 0;
    int cyc      = 0;
    bit checkEn  = 0;

    // Model state per instance
    bit          pend   [2];
    int          respAt [2];
    bit          pWe    [2];
    bit          pErr   [2];
    logic [3:0]  pBe    [2];
    int          pIdx   [2];
    logic [31:0] pWdata [2];
    logic [31:0] mMem   [2][256];

    // Observations of the DUT outputs
    int          respCnt     [2];
    int          busyCnt     [2];
    int          lastRespCyc [2];
    int          prevRespCyc [2];
    logic [31:0] lastData    [2];
    logic [31:0] prevData    [2];
    logic        lastErr     [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dutW2 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_we(reqWe), .req_be(reqBe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .addr_err(addrErr[0]), .mem_busy(memBusy[0])
    );

    data_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dutW0 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_we(reqWe), .req_be(reqBe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .addr_err(addrErr[1]), .mem_busy(memBusy[1])
    );

    function automatic int waitOf(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle compare and model update, sampled mid-cycle
    initial begin
        logic        expReady;
        logic        expErr;
        logic        expBusy;
        logic [31:0] expData;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                for (int i = 0; i < 2; i++) begin
                    expReady = pend[i] && (cyc == respAt[i]);
                    expErr   = expReady && pErr[i];
                    expData  = (expReady && !pErr[i] && !pWe[i]) ? mMem[i][pIdx[i]] : 32'd0;
                    expBusy  = pend[i] ? (cyc < respAt[i]) : reqValid;
                    check($sformatf("resp_ready[w%0d]", waitOf(i)), 32'(respReady[i]), 32'(expReady));
                    check($sformatf("addr_err[w%0d]", waitOf(i)), 32'(addrErr[i]), 32'(expErr));
                    check($sformatf("resp_rdata[w%0d]", waitOf(i)), respRdata[i], expData);
                    check($sformatf("mem_busy[w%0d]", waitOf(i)), 32'(memBusy[i]), 32'(expBusy));

                    if (respReady[i]) begin
                        prevRespCyc[i] = lastRespCyc[i];
                        prevData[i]    = lastData[i];
                        lastRespCyc[i] = cyc;
                        lastData[i]    = respRdata[i];
                        lastErr[i]     = addrErr[i];
                        respCnt[i]++;
                    end
                    if (memBusy[i]) busyCnt[i]++;

                    if (reset) begin
                        pend[i] = 0;
                    end else if (pend[i] && cyc == respAt[i]) begin
                        if (pWe[i] && !pErr[i])
                            for (int b = 0; b < 4; b++)
                                if (pBe[i][b]) mMem[i][pIdx[i]][8*b +: 8] = pWdata[i][8*b +: 8];
                        pend[i] = 0;
                    end else if (!pend[i] && reqValid) begin
                        pend[i]   = 1;
                        respAt[i] = cyc + waitOf(i) + 1;
                        pWe[i]    = reqWe;
                        pBe[i]    = reqBe;
                        pWdata[i] = reqWdata;
                        pIdx[i]   = int'((reqAddr >> 2) & 32'd255);
                        pErr[i]   = (reqAddr % 4 != 0) || (reqAddr >= 32'd1024);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic drive(input bit v, input bit we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d, input bit r);
        @(posedge clk);
        #1;
        reset    = r;
        reqValid = v;
        reqWe    = we;
        reqBe    = be;
        reqAddr  = a;
        reqWdata = d;
    endtask

    task automatic idleCyc();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic waitBoth(input int n0, input int n1);
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            idleCyc();
            @(negedge clk);
            #1;
            done = (respCnt[0] > n0) && (respCnt[1] > n1);
        end
        check("req_timeout", 32'(done), 32'd1);
    endtask

    task automatic doReq(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        int n0 = respCnt[0];
        int n1 = respCnt[1];
        drive(1, we, be, a, d, 0);
        waitBoth(n0, n1);
    endtask

    initial begin
        int a;
        int n0;
        int n1;
        int b0;
        int b1;
        reset = 1; reqValid = 0; reqWe = 0; reqBe = 0; reqAddr = 0; reqWdata = 0;
        @(posedge clk);
        #1;
        checkEn = 1;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1);
        idleCyc();
        @(negedge clk);
        #1;
        check("rst_resp_ready", 32'(respReady[0]), 32'd0);
        check("rst_resp_rdata", respRdata[0], 32'd0);
        check("rst_addr_err", 32'(addrErr[0]), 32'd0);
        check("rst_mem_busy", 32'(memBusy[0]), 32'd0);

        for (int w = 0; w < 16; w++)
            doReq(1, 4'hF, 32'(w * 4), 32'hA5000000 | 32'(w * 32'h00010101));

        b0 = busyCnt[0]; b1 = busyCnt[1];
        drive(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
        a = cyc;
        waitBoth(respCnt[0], respCnt[1]);
        check("store_busy_cycles_w2", 32'(busyCnt[0] - b0), 32'd3);
        check("store_busy_cycles_w0", 32'(busyCnt[1] - b1), 32'd1);
        check("store_latency_w2", 32'(lastRespCyc[0] - a), 32'd3);
        check("store_latency_w0", 32'(lastRespCyc[1] - a), 32'd1);
        doReq(0, 4'h0, 32'h10, 32'h0);
        check("load_deadbeef", lastData[0], 32'hDEADBEEF);
        check("load_deadbeef_err", 32'(lastErr[0]), 32'd0);

        doReq(1, 4'b0101, 32'h10, 32'h11223344);
        check("model_bytemask", mMem[0][4], 32'hDE22BE44);
        doReq(0, 4'h0, 32'h10, 32'h0);
        check("load_bytemask_w2", lastData[0], 32'hDE22BE44);
        check("load_bytemask_w0", lastData[1], 32'hDE22BE44);

        doReq(0, 4'h0, 32'h13, 32'h0);
        check("misaligned_err", 32'(lastErr[0]), 32'd1);
        check("misaligned_data", lastData[0], 32'd0);
        doReq(1, 4'hF, 32'h0, 32'h0BADC0DE);
        doReq(1, 4'hF, 32'h400, 32'hFFFFFFFF);
        check("range_err", 32'(lastErr[0]), 32'd1);
        doReq(0, 4'h0, 32'h0, 32'h0);
        check("range_no_write", lastData[0], 32'h0BADC0DE);

        doReq(1, 4'hF, 32'h20, 32'h55AA55AA);
        n0 = respCnt[0];
        drive(1, 1, 4'hF, 32'h20, 32'h12345678, 0);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1);
        repeat (4) idleCyc();
        @(negedge clk);
        #1;
        check("abort_no_resp", 32'(respCnt[0]), 32'(n0));
        doReq(0, 4'h0, 32'h20, 32'h0);
        check("abort_keeps_w2", lastData[0], 32'h55AA55AA);
        check("abort_keeps_w0", lastData[1], 32'h55AA55AA);

        doReq(1, 4'hF, 32'h14, 32'hCAFEF00D);
        n0 = respCnt[0]; n1 = respCnt[1];
        drive(1, 0, 4'h0, 32'h10, 32'h0, 0);
        a = cyc;
        drive(1, 0, 4'h0, 32'h14, 32'h0, 0);
        drive(1, 0, 4'h0, 32'h14, 32'h0, 0);
        repeat (4) idleCyc();
        @(negedge clk);
        #1;
        check("b2b_count_w0", 32'(respCnt[1] - n1), 32'd2);
        check("b2b_count_w2", 32'(respCnt[0] - n0), 32'd1);
        check("b2b_first_cyc", 32'(prevRespCyc[1] - a), 32'd1);
        check("b2b_second_cyc", 32'(lastRespCyc[1] - a), 32'd3);
        check("b2b_first_data", prevData[1], 32'hDE22BE44);
        check("b2b_second_data", lastData[1], 32'hCAFEF00D);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] addr;
            int r = int'($urandom_range(0, 9));
            int idx = int'($urandom_range(0, 15));
            if (r < 7)       addr = 32'(idx * 4);
            else if (r == 7) addr = 32'(idx * 4) + 32'($urandom_range(1, 3));
            else             addr = (32'($urandom_range(1, 32'h3FFFFF)) << 10) | 32'(idx * 4);
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  addr, $urandom, ($urandom_range(0, 63) == 0));
        end
        repeat (6) idleCyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
